sram_port_arb: RTL and testbench

SRAM_PORT_ARB -- requirements
Module: sram_port_arb

---
 rtl/sram_port_arb_pkg.sv | 22 ++
 rtl/sram_port_arb_if.sv | 31 +++
 rtl/sram_port_arb_addr_xlate.sv | 30 +++
 rtl/sram_port_arb.sv | 184 ++++++++++++++++++
 tb/tb_sram_port_arb.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arb_pkg.sv
// Shared CPU bus definitions: default widths, arbiter FSM state encoding,
// and the MIPS kseg0/kseg1 window constants used by address translation.
// No ports; imported by the arbiter, its bus interface and addr_xlate.
package cpu_bus_pkg;

  localparam int NUM_CH_DEF = 2;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  // Arbiter FSM state encoding
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_ADDR = 2'd1;
  localparam arb_state_t ST_DATA = 2'd2;

  // kseg0 starts at KSEG0_BASE, kseg1 at KSEG1_BASE, both end below KSEG2_BASE
  localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
  localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
  localparam logic [31:0] KSEG2_BASE = 32'hC000_0000;
  localparam logic [31:0] KSEG_PMASK = 32'h1FFF_FFFF;

endpackage

// File: rtl/sram_port_arb_if.sv
// Memory-side SRAM-like bus between the arbiter and the memory system.
// master: drives mem_req/mem_wr/mem_wen/mem_paddr/mem_wdata/mem_uncached,
// receives mem_addr_ok/mem_data_ok/mem_rdata. slave: the reverse.
interface sram_port_arb_if
  import cpu_bus_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic                  mem_req;
  logic                  mem_wr;
  logic [DATA_W/8-1:0]   mem_wen;
  logic [ADDR_W-1:0]     mem_paddr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_uncached;
  logic                  mem_addr_ok;
  logic                  mem_data_ok;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_wen, mem_paddr, mem_wdata, mem_uncached,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_wen, mem_paddr, mem_wdata, mem_uncached,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/sram_port_arb_addr_xlate.sv
// addr_xlate: combinational virtual-to-physical mapping, zero latency, no backpressure.
// Ports: vaddr in, paddr out, uncached out.
// With ADDR_TRANS_EN defined, kseg0/kseg1 fold onto low memory and kseg1 is
// flagged uncached; otherwise addresses pass straight through, always cached.
module addr_xlate
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] vaddr,
  output logic [ADDR_W-1:0] paddr,
  output logic              uncached
);

`ifdef ADDR_TRANS_EN
  logic in_kseg01;
  logic in_kseg1;

  always_comb begin
    in_kseg01 = (vaddr >= ADDR_W'(KSEG0_BASE)) && (vaddr < ADDR_W'(KSEG2_BASE));
    in_kseg1  = (vaddr >= ADDR_W'(KSEG1_BASE)) && (vaddr < ADDR_W'(KSEG2_BASE));
    paddr     = in_kseg01 ? (vaddr & ADDR_W'(KSEG_PMASK)) : vaddr;
    uncached  = in_kseg1;
  end
`else
  assign paddr    = vaddr;
  assign uncached = 1'b0;
`endif

endmodule

// File: rtl/sram_port_arb.sv
// sram_port_arb: round-robin arbiter of NUM_CH CPU channels onto one SRAM-like bus.
// Latency: request in cycle 0 -> mem_req cycle 1 -> data_ok earliest cycle 2 -> result cycle 3.
// Backpressure: ch_stall holds a channel until its access is done; mem_addr_ok/mem_data_ok pace the FSM.
// Ports: clk/rst (sync, active-high), hold (pipeline stall window), ch_* per-channel
// request/response buses (channel i in slice i), mem (sram_port_arb_if master).
// Build option: define ADDR_TRANS_EN to enable kseg0/kseg1 translation in addr_xlate.
module sram_port_arb
  import cpu_bus_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           hold,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH-1:0]              ch_wr,
  input  logic [NUM_CH*(DATA_W/8)-1:0]   ch_wen,
  input  logic [NUM_CH*ADDR_W-1:0]       ch_vaddr,
  input  logic [NUM_CH*DATA_W-1:0]       ch_wdata,
  output logic [NUM_CH*DATA_W-1:0]       ch_rdata,
  output logic [NUM_CH-1:0]              ch_stall,
  sram_port_arb_if.master                mem
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t         state_q;
  logic [1:0]         rr_ptr_q;
  logic [1:0]         grant_q;
  logic [NUM_CH-1:0]  done_q;
  logic               wr_q;
  logic [BE_W-1:0]    wen_q;
  logic [ADDR_W-1:0]  vaddr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q [NUM_CH];

  logic [NUM_CH-1:0]  pend;
  logic [3:0]         pend_pad;
  logic [2:0]         cand;
  logic               gnt_vld;
  logic [1:0]         gnt_idx;
  logic [2:0]         grant_inc;
  logic [1:0]         rr_next;
  logic               complete;

  logic               sel_wr;
  logic [BE_W-1:0]    sel_wen;
  logic [ADDR_W-1:0]  sel_vaddr;
  logic [DATA_W-1:0]  sel_wdata;

  logic [ADDR_W-1:0]  paddr;
  logic               uncached;

  // A channel is pending until it has been served once in this stall window
  assign pend = ch_req & ~done_q;

  // During reset done_q may still hold stale bits, so stall simply follows ch_req
  assign ch_stall = ch_req & ~(done_q & {NUM_CH{~rst}});

  // Round-robin search starting at rr_ptr_q; the pad keeps indexing a fixed 4 bits
  always_comb begin
    pend_pad               = '0;
    pend_pad[NUM_CH-1:0]   = pend;
    cand                   = '0;
    gnt_vld                = 1'b0;
    gnt_idx                = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, rr_ptr_q} + 3'(k);
      if (cand >= 3'(NUM_CH)) begin
        cand = cand - 3'(NUM_CH);
      end
      if (!gnt_vld && pend_pad[cand[1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[1:0];
      end
    end
  end

  always_comb begin
    sel_wr    = 1'b0;
    sel_wen   = '0;
    sel_vaddr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == 2'(i)) begin
        sel_wr    = ch_wr[i];
        sel_wen   = ch_wen[i*BE_W +: BE_W];
        sel_vaddr = ch_vaddr[i*ADDR_W +: ADDR_W];
        sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // With NUM_CH=1 this always wraps back to 0
  assign grant_inc = {1'b0, grant_q} + 3'd1;
  assign rr_next   = (grant_inc >= 3'(NUM_CH)) ? 2'd0 : grant_inc[1:0];

  // data_ok only counts in DATA; in IDLE/ADDR it is dropped
  assign complete = (state_q == ST_DATA) && mem.mem_data_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      wr_q     <= 1'b0;
      wen_q    <= '0;
      vaddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            state_q <= ST_ADDR;
            grant_q <= gnt_idx;
            wr_q    <= sel_wr;
            wen_q   <= sel_wen;
            vaddr_q <= sel_vaddr;
            wdata_q <= sel_wdata;
          end
        end
        ST_ADDR: begin
          if (mem.mem_addr_ok) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mem.mem_data_ok) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= rr_next;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // done is only set if the channel is still asking at completion; an abandoned
  // request must not suppress that channel's next real access
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        done_q[i] <= 1'b0;
      end else if (complete && (grant_q == 2'(i)) && ch_req[i]) begin
        done_q[i] <= 1'b1;
      end else if (!hold) begin
        done_q[i] <= 1'b0;
      end
    end
  end

  // Stores leave the channel's read data untouched
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        rdata_q[i] <= '0;
      end else if (complete && !wr_q && (grant_q == 2'(i))) begin
        rdata_q[i] <= mem.mem_rdata;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_rdata
    assign ch_rdata[g*DATA_W +: DATA_W] = rdata_q[g];
  end

  addr_xlate #(
    .ADDR_W (ADDR_W)
  ) u_xlate (
    .vaddr    (vaddr_q),
    .paddr    (paddr),
    .uncached (uncached)
  );

  assign mem.mem_req      = (state_q == ST_ADDR) && !rst;
  assign mem.mem_wr       = wr_q;
  assign mem.mem_wen      = wen_q;
  assign mem.mem_paddr    = paddr;
  assign mem.mem_wdata    = wdata_q;
  assign mem.mem_uncached = uncached;

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb with NUM_CH=2, 32-bit data and address.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Expected translation results follow the ADDR_TRANS_EN build option.
module tb_sram_port_arb;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = DATA_W / 8;

`ifdef ADDR_TRANS_EN
  localparam logic [31:0] EXP_BOOT_PA  = 32'h1FC0_0000;
  localparam logic        EXP_BOOT_UNC = 1'b1;
  localparam logic [31:0] EXP_K1_PA    = 32'h0000_0004;
  localparam logic        EXP_K1_UNC   = 1'b1;
  localparam logic [31:0] EXP_ST_PA    = 32'h0000_0010;
`else
  localparam logic [31:0] EXP_BOOT_PA  = 32'hBFC0_0000;
  localparam logic        EXP_BOOT_UNC = 1'b0;
  localparam logic [31:0] EXP_K1_PA    = 32'hA000_0004;
  localparam logic        EXP_K1_UNC   = 1'b0;
  localparam logic [31:0] EXP_ST_PA    = 32'h8000_0010;
`endif

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         hold;
  logic [NUM_CH-1:0]            ch_req;
  logic [NUM_CH-1:0]            ch_wr;
  logic [NUM_CH*BE_W-1:0]       ch_wen;
  logic [NUM_CH*ADDR_W-1:0]     ch_vaddr;
  logic [NUM_CH*DATA_W-1:0]     ch_wdata;
  logic [NUM_CH*DATA_W-1:0]     ch_rdata;
  logic [NUM_CH-1:0]            ch_stall;

  int checks = 0;
  int errors = 0;
  int nreq;

  sram_port_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem ();

  sram_port_arb #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .ch_req   (ch_req),
    .ch_wr    (ch_wr),
    .ch_wen   (ch_wen),
    .ch_vaddr (ch_vaddr),
    .ch_wdata (ch_wdata),
    .ch_rdata (ch_rdata),
    .ch_stall (ch_stall),
    .mem      (mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic req, input logic wr, input logic [BE_W-1:0] wen,
                        input logic [31:0] va, input logic [31:0] wd);
    ch_req[c]                   = req;
    ch_wr[c]                    = wr;
    ch_wen[c*BE_W +: BE_W]      = wen;
    ch_vaddr[c*ADDR_W +: ADDR_W] = va;
    ch_wdata[c*DATA_W +: DATA_W] = wd;
  endtask

  // Called during cycle 0 of a granted request; returns 1 ns into cycle 3.
  // addr_ok in cycle 1, data_ok with rd in cycle 2.
  task automatic run_txn(input string tag, input logic [31:0] pa, input logic unc, input logic wr,
                         input logic [3:0] wen, input logic [31:0] wd, input logic [31:0] rd);
    tick();
    mem.mem_addr_ok = 1'b1;
    #4;
    chk({tag, "_req"},   mem.mem_req,      1'b1);
    chk({tag, "_pa"},    mem.mem_paddr,    pa);
    chk({tag, "_unc"},   mem.mem_uncached, unc);
    chk({tag, "_wr"},    mem.mem_wr,       wr);
    chk({tag, "_wen"},   mem.mem_wen,      wen);
    chk({tag, "_wdata"}, mem.mem_wdata,    wd);
    tick();
    mem.mem_addr_ok = 1'b0;
    mem.mem_data_ok = 1'b1;
    mem.mem_rdata   = rd;
    #4;
    chk({tag, "_req_off"}, mem.mem_req, 1'b0);
    tick();
    mem.mem_data_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hold = 1'b0;
    ch_req = '0; ch_wr = '0; ch_wen = '0; ch_vaddr = '0; ch_wdata = '0;
    mem.mem_addr_ok = 1'b0; mem.mem_data_ok = 1'b0; mem.mem_rdata = '0;

    // Reset with ch0 already requesting a boot fetch
    set_ch(0, 1'b1, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0);
    tick(); tick(); #4;
    chk("rst_mem_req", mem.mem_req, 1'b0);
    chk("rst_stall",   ch_stall, 2'b01);
    chk("rst_rdata0",  ch_rdata[31:0], 32'h0);
    chk("rst_rdata1",  ch_rdata[63:32], 32'h0);

    // Single load, minimum latency
    tick(); rst = 1'b0; #4;
    chk("c0_mem_req", mem.mem_req, 1'b0);
    chk("c0_stall",   ch_stall, 2'b01);
    run_txn("boot", EXP_BOOT_PA, EXP_BOOT_UNC, 1'b0, 4'h0, 32'h0, 32'h2402_0001);
    #4;
    chk("boot_stall_c3", ch_stall, 2'b00);
    chk("boot_rdata",    ch_rdata[31:0], 32'h2402_0001);
    tick(); set_ch(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // kseg1 address
    tick(); set_ch(0, 1'b1, 1'b0, 4'h0, 32'hA000_0004, 32'h0);
    run_txn("kseg1", EXP_K1_PA, EXP_K1_UNC, 1'b0, 4'h0, 32'h0, 32'h1111_2222);
    #4;
    chk("kseg1_rdata", ch_rdata[31:0], 32'h1111_2222);
    tick(); set_ch(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0); rst = 1'b1;

    // Contention right after reset: ch0 then ch1
    tick(); rst = 1'b0; hold = 1'b1;
    set_ch(0, 1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'h0);
    set_ch(1, 1'b1, 1'b0, 4'h0, 32'h0000_2000, 32'h0);
    #4;
    chk("rst2_rdata0", ch_rdata[31:0], 32'h0);
    chk("cont_stall",  ch_stall, 2'b11);
    run_txn("cont_ch0", 32'h0000_1000, 1'b0, 1'b0, 4'h0, 32'h0, 32'hAAAA_0000);
    #4;
    chk("cont_mid_stall", ch_stall, 2'b10);
    run_txn("cont_ch1", 32'h0000_2000, 1'b0, 1'b0, 4'h0, 32'h0, 32'hBBBB_0000);
    #4;
    chk("cont_end_stall", ch_stall, 2'b00);
    chk("cont_rdata0",    ch_rdata[31:0],  32'hAAAA_0000);
    chk("cont_rdata1",    ch_rdata[63:32], 32'hBBBB_0000);

    // Serve ch0 alone so the pointer moves to ch1, then contend again
    tick(); hold = 1'b0; ch_req = '0;
    tick(); hold = 1'b1; set_ch(0, 1'b1, 1'b0, 4'h0, 32'h0000_3000, 32'h0);
    run_txn("solo_ch0", 32'h0000_3000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h3333_0000);
    tick(); ch_req = '0; hold = 1'b0;
    tick(); hold = 1'b1;
    set_ch(0, 1'b1, 1'b0, 4'h0, 32'h0000_4000, 32'h0);
    set_ch(1, 1'b1, 1'b0, 4'h0, 32'h0000_5000, 32'h0);
    run_txn("rr_ch1", 32'h0000_5000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h5555_0000);
    run_txn("rr_ch0", 32'h0000_4000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h4444_0000);
    #4;
    chk("rr_rdata1", ch_rdata[63:32], 32'h5555_0000);
    chk("rr_rdata0", ch_rdata[31:0],  32'h4444_0000);
    tick(); ch_req = '0; hold = 1'b0;

    // Store inside a hold window: one access only, read data untouched
    tick(); hold = 1'b1; set_ch(1, 1'b1, 1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF);
    run_txn("st1", EXP_ST_PA, 1'b0, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h9999_9999);
    #4;
    chk("st1_rdata1_kept", ch_rdata[63:32], 32'h5555_0000);
    chk("st1_stall",       ch_stall, 2'b00);
    nreq = 0;
    for (int k = 0; k < 5; k++) begin
      tick(); #4;
      if (mem.mem_req) nreq++;
    end
    chk("hold_one_req", nreq, 0);
    tick(); hold = 1'b0; #4;
    chk("hold_rel_stall", ch_stall, 2'b00);
    tick(); hold = 1'b1; #4;
    chk("hold_rel_restall", ch_stall, 2'b10);
    run_txn("st2", EXP_ST_PA, 1'b0, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0);
    #4;
    chk("st2_rdata1_kept", ch_rdata[63:32], 32'h5555_0000);
    tick(); set_ch(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // ch0 abandons its read during DATA (hold stays high)
    tick(); set_ch(0, 1'b1, 1'b0, 4'h0, 32'h0000_6000, 32'h0);
    tick(); mem.mem_addr_ok = 1'b1;
    tick(); mem.mem_addr_ok = 1'b0; mem.mem_data_ok = 1'b1; mem.mem_rdata = 32'h7777_0000;
    ch_req[0] = 1'b0;
    tick(); mem.mem_data_ok = 1'b0; #4;
    chk("abort_rdata0",  ch_rdata[31:0], 32'h7777_0000);
    chk("abort_stall",   ch_stall, 2'b00);
    chk("abort_mem_req", mem.mem_req, 1'b0);
    nreq = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); #4;
      if (mem.mem_req) nreq++;
    end
    chk("abort_no_new_req", nreq, 0);
    tick(); ch_req[0] = 1'b1; #4;
    chk("abort_done0_clear", ch_stall, 2'b01);

    // Reset while in DATA, then a late data_ok
    tick(); mem.mem_addr_ok = 1'b1; #4;
    chk("rstmid_c1_req", mem.mem_req, 1'b1);
    tick(); mem.mem_addr_ok = 1'b0; rst = 1'b1; ch_req = '0; #4;
    chk("rstmid_req", mem.mem_req, 1'b0);
    tick(); rst = 1'b0; mem.mem_data_ok = 1'b1; mem.mem_rdata = 32'h5A5A_5A5A; #4;
    chk("rstmid_req_idle", mem.mem_req, 1'b0);
    tick(); mem.mem_data_ok = 1'b0; #4;
    chk("rstmid_rdata0", ch_rdata[31:0],  32'h0);
    chk("rstmid_rdata1", ch_rdata[63:32], 32'h0);
    tick(); #4;
    chk("rstmid_still_idle", mem.mem_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
